// File: rtl/axis_spi_stream.sv
// rtl/axis_spi_stream.sv - SPI slave to AXI-Stream bridge with RX/TX FIFOs and sticky status
//
// axis_spi_fifo   : first-word-fall-through FIFO with an extra pointer bit for full/level
//   clk_i, reset_i          clock, synchronous active-high reset
//   push_i, data_i          write request and data (accepted when not full, or full with a pop)
//   pop_i, data_o           read request and head-of-queue data
//   full_o, empty_o         occupancy flags
//   level_o                 occupancy 0..DEPTH
//
// axis_spi_stream : host MOSI words -> RX FIFO -> master stream, tlast on the final word of a
//                   chip-select frame; slave stream -> TX FIFO -> MISO
//   i_clk, i_reset          system clock, synchronous active-high reset
//   i_spi_clk/mosi/cs_n     asynchronous SPI pins (2-flop synchronised)
//   o_spi_miso, _oe         MISO data and enable
//   i_axis_t*, o_axis_tready   TX stream into the TX FIFO
//   o_axis_t*, i_axis_tready   RX stream out of the RX FIFO
//   o_rx_level, o_tx_level  FIFO occupancies
//   o_rx_overflow           sticky: RX word dropped on a full FIFO
//   o_tx_underrun           sticky: IDLE_WORD loaded because the TX FIFO was empty
//   i_clear_status          clears both sticky flags (a same-cycle event wins)

module axis_spi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
   assign do_push = push_i & (~full_o | do_pop);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end
endmodule

module axis_spi_stream #(
   parameter int                DATA_W    = 8,
   parameter int                RX_DEPTH  = 16,
   parameter int                TX_DEPTH  = 16,
   parameter int                CPOL      = 0,
   parameter int                CPHA      = 0,
   parameter logic [DATA_W-1:0] IDLE_WORD = 'hFF
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_spi_clk,
   input  logic                      i_spi_mosi,
   input  logic                      i_spi_cs_n,
   output logic                      o_spi_miso,
   output logic                      o_spi_miso_oe,
   input  logic [DATA_W-1:0]         i_axis_tdata,
   input  logic                      i_axis_tvalid,
   output logic                      o_axis_tready,
   output logic [DATA_W-1:0]         o_axis_tdata,
   output logic                      o_axis_tvalid,
   input  logic                      i_axis_tready,
   output logic                      o_axis_tlast,
   output logic [$clog2(RX_DEPTH):0] o_rx_level,
   output logic [$clog2(TX_DEPTH):0] o_tx_level,
   output logic                      o_rx_overflow,
   output logic                      o_tx_underrun,
   input  logic                      i_clear_status
);
   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic            CPOL_B   = (CPOL != 0);
   localparam logic            CPHA_B   = (CPHA != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_FLUSH
   } state_e;

   // Synchronisers: index 1 is the synchronised value, index 2 its previous value for edges.
   logic [2:0]        sclk_q;
   logic [1:0]        mosi_q;
   logic [2:0]        cs_q;
   logic              armed_q;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] stage_q, stage_d;
   logic              stage_valid_q, stage_valid_d;
   logic              ovf_q, und_q;

   logic              sclk_rise, sclk_fall;
   logic              lead_edge, trail_edge;
   logic              sample_edge, shift_edge;
   logic              cs_fall;
   logic [DATA_W-1:0] rx_word;

   logic              rx_push;
   logic [DATA_W:0]   rx_push_data;
   logic              rx_pop;
   logic [DATA_W:0]   rx_dout;
   logic              rx_full, rx_empty;
   logic              rx_drop;

   logic              tx_push;
   logic              tx_pop;
   logic              tx_load;
   logic [DATA_W-1:0] tx_dout;
   logic              tx_full, tx_empty;

   assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
   // Leading edge leaves the CPOL idle level.
   assign lead_edge   = CPOL_B ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL_B ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA_B ? trail_edge : lead_edge;
   assign shift_edge  = CPHA_B ? lead_edge : trail_edge;

   // The CS synchroniser resets to "low"; armed_q only rises once the pin has really been seen
   // high, so a CS held low across reset can neither start a frame nor enable MISO.
   assign cs_fall       = armed_q & cs_q[2] & ~cs_q[1];
   assign o_spi_miso_oe = armed_q & ~cs_q[1];
   assign o_spi_miso    = o_spi_miso_oe & tx_shift_q[DATA_W-1];

   assign rx_word = {rx_shift_q[DATA_W-2:0], mosi_q[1]};

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      stage_d       = stage_q;
      stage_valid_d = stage_valid_q;
      rx_push       = 1'b0;
      rx_push_data  = '0;
      tx_load       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d   = S_ACTIVE;
               bit_cnt_d = '0;
               tx_load   = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (cs_q[1]) begin
               state_d = S_FLUSH;
            end else if (sample_edge) begin
               rx_shift_d = rx_word;
               if (bit_cnt_q == CNT_LAST) begin
                  bit_cnt_d = '0;
                  tx_load   = 1'b1;
                  // The staging register delays each word by one so the frame's last word
                  // can be tagged with tlast when CS rises.
                  if (stage_valid_q) begin
                     rx_push      = 1'b1;
                     rx_push_data = {1'b0, stage_q};
                  end
                  stage_d       = rx_word;
                  stage_valid_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (shift_edge && (bit_cnt_q != '0)) begin
               // At count 0 MISO already shows a freshly loaded MSB that must not be skipped.
               tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
         end
         S_FLUSH: begin
            state_d = S_IDLE;
            if (stage_valid_q) begin
               rx_push      = 1'b1;
               rx_push_data = {1'b1, stage_q};
            end
            stage_valid_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      if (tx_load) begin
         tx_shift_d = tx_empty ? IDLE_WORD : tx_dout;
      end
   end

   assign tx_pop  = tx_load & ~tx_empty;
   assign tx_push = i_axis_tvalid & ~tx_full;
   assign rx_pop  = i_axis_tready & ~rx_empty;
   assign rx_drop = rx_push & rx_full & ~rx_pop;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sclk_q        <= {3{CPOL_B}};
         mosi_q        <= '0;
         cs_q          <= '0;
         armed_q       <= 1'b0;
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         stage_q       <= '0;
         stage_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
         und_q         <= 1'b0;
      end else begin
         sclk_q        <= {sclk_q[1:0], i_spi_clk};
         mosi_q        <= {mosi_q[0], i_spi_mosi};
         cs_q          <= {cs_q[1:0], i_spi_cs_n};
         armed_q       <= armed_q | cs_q[1];
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         stage_q       <= stage_d;
         stage_valid_q <= stage_valid_d;
         ovf_q         <= (ovf_q & ~i_clear_status) | rx_drop;
         und_q         <= (und_q & ~i_clear_status) | (tx_load & tx_empty);
      end
   end

   axis_spi_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .push_i  (rx_push),
      .data_i  (rx_push_data),
      .pop_i   (rx_pop),
      .data_o  (rx_dout),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (o_rx_level)
   );

   axis_spi_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .push_i  (tx_push),
      .data_i  (i_axis_tdata),
      .pop_i   (tx_pop),
      .data_o  (tx_dout),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (o_tx_level)
   );

   assign o_axis_tready = ~tx_full;
   assign o_axis_tvalid = ~rx_empty;
   assign o_axis_tdata  = rx_empty ? '0 : rx_dout[DATA_W-1:0];
   assign o_axis_tlast  = ~rx_empty & rx_dout[DATA_W];
   assign o_rx_overflow = ovf_q;
   assign o_tx_underrun = und_q;
endmodule

// File: tb/tb_axis_spi_stream.sv
// tb/tb_axis_spi_stream.sv - self-checking bench for axis_spi_stream in all four SPI modes
module tb_axis_spi_stream;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         clr;
   logic         mosi;
   logic [W-1:0] s_tdata;
   logic         spi_clk  [4];
   logic         cs_n     [4];
   logic         miso     [4];
   logic         miso_oe  [4];
   logic         s_tvalid [4];
   logic         s_tready [4];
   logic [W-1:0] m_tdata  [4];
   logic         m_tvalid [4];
   logic         m_tready [4];
   logic         m_tlast  [4];
   logic [2:0]   rx_level [4];
   logic [4:0]   tx_level [4];
   logic         rx_ovf   [4];
   logic         tx_und   [4];

   int errors = 0;
   int checks = 0;
   logic [W:0] exp_q [$];
   logic [W:0] got_q [$];

   // Instance g runs SPI mode g: CPOL = g/2, CPHA = g%2.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      axis_spi_stream #(
         .DATA_W(W), .RX_DEPTH(4), .TX_DEPTH(16), .CPOL(g / 2), .CPHA(g % 2), .IDLE_WORD('hFF)
      ) u_dut (
         .i_clk          (clk),
         .i_reset        (rst),
         .i_spi_clk      (spi_clk[g]),
         .i_spi_mosi     (mosi),
         .i_spi_cs_n     (cs_n[g]),
         .o_spi_miso     (miso[g]),
         .o_spi_miso_oe  (miso_oe[g]),
         .i_axis_tdata   (s_tdata),
         .i_axis_tvalid  (s_tvalid[g]),
         .o_axis_tready  (s_tready[g]),
         .o_axis_tdata   (m_tdata[g]),
         .o_axis_tvalid  (m_tvalid[g]),
         .i_axis_tready  (m_tready[g]),
         .o_axis_tlast   (m_tlast[g]),
         .o_rx_level     (rx_level[g]),
         .o_tx_level     (tx_level[g]),
         .o_rx_overflow  (rx_ovf[g]),
         .o_tx_underrun  (tx_und[g]),
         .i_clear_status (clr)
      );
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic axis_push(input int m, input logic [W-1:0] d);
      @(negedge clk);
      s_tdata     = d;
      s_tvalid[m] = 1'b1;
      @(negedge clk);
      s_tvalid[m] = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
   endtask

   // SPI master: SCLK period 16 i_clk cycles. Samples MISO on the mode's sample edge.
   task automatic spi_xfer(input int m, input logic [63:0] data, input int nbits,
                           input bit end_frame, output logic [63:0] mb);
      logic cpol;
      logic cpha;
      cpol = (m / 2) != 0;
      cpha = (m % 2) != 0;
      mb = '0;
      cs_n[m] = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = data[nbits-1-i];
            #80;
            mb = {mb[62:0], miso[m]};
            spi_clk[m] = ~cpol;
            #80;
            spi_clk[m] = cpol;
         end else begin
            spi_clk[m] = ~cpol;
            mosi = data[nbits-1-i];
            #80;
            mb = {mb[62:0], miso[m]};
            spi_clk[m] = cpol;
            #80;
         end
      end
      if (end_frame) begin
         #80;
         cs_n[m] = 1'b1;
         #200;
      end
   endtask

   // Pulls everything the RX stream offers within a bounded window into got_q.
   task automatic collect(input int m);
      got_q.delete();
      @(negedge clk);
      m_tready[m] = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (m_tvalid[m]) got_q.push_back({m_tlast[m], m_tdata[m]});
         @(negedge clk);
      end
      m_tready[m] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
         checks++; if (m_tvalid[m] !== 1'b0) begin errors++; $display("FAIL reset_tvalid[%0d] got %b want 0", m, m_tvalid[m]); end
         checks++; if (s_tready[m] !== 1'b1) begin errors++; $display("FAIL reset_tready[%0d] got %b want 1", m, s_tready[m]); end
         checks++; if ({miso[m], miso_oe[m]} !== 2'b00) begin errors++; $display("FAIL reset_miso[%0d] got %b want 00", m, {miso[m], miso_oe[m]}); end
         checks++; if ({rx_level[m], tx_level[m]} !== 8'd0) begin errors++; $display("FAIL reset_levels[%0d] got %0d/%0d want 0/0", m, rx_level[m], tx_level[m]); end
         checks++; if ({rx_ovf[m], tx_und[m], m_tlast[m], m_tdata[m]} !== 11'd0) begin errors++; $display("FAIL reset_flags[%0d] got %b want 0", m, {rx_ovf[m], tx_und[m], m_tlast[m], m_tdata[m]}); end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_mode0_frame();
      logic [63:0] mb;
      logic [W:0]  e, g;
      axis_push(0, 8'h11);
      axis_push(0, 8'h22);
      axis_push(0, 8'h33);
      checks++; if (tx_level[0] !== 5'd3) begin errors++; $display("FAIL mode0_tx_level got %0d want 3", tx_level[0]); end
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, 8'h3C});
      exp_q.push_back({1'b1, 8'hFF});
      spi_xfer(0, 64'hA53CFF, 24, 1'b1, mb);
      checks++; if (mb[23:0] !== 24'h112233) begin errors++; $display("FAIL mode0_miso got %h want 112233", mb[23:0]); end
      checks++; if (rx_level[0] !== 3'd3) begin errors++; $display("FAIL mode0_rx_level got %0d want 3", rx_level[0]); end
      collect(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++; if (g !== e) begin errors++; $display("FAIL mode0_rx got %h want %h", g, e); end
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mode0_extra got %0d words want 0", got_q.size()); end
   endtask

   task automatic test_modes();
      logic [63:0] mb;
      logic [W:0]  e, g;
      for (int m = 1; m < 4; m++) begin
         axis_push(m, 8'h5A);
         exp_q.push_back({1'b1, 8'h5A});
         spi_xfer(m, 64'h5A, 8, 1'b1, mb);
         checks++; if (mb[7:0] !== 8'h5A) begin errors++; $display("FAIL mode%0d_miso got %h want 5a", m, mb[7:0]); end
         collect(m);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
            checks++; if (g !== e) begin errors++; $display("FAIL mode%0d_rx got %h want %h", m, g, e); end
         end
         checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mode%0d_extra got %0d words want 0", m, got_q.size()); end
      end
   endtask

   task automatic test_underrun();
      logic [63:0] mb;
      logic [W:0]  e, g;
      pulse_clear();
      checks++; if (tx_und[0] !== 1'b0) begin errors++; $display("FAIL underrun_precleared got %b want 0", tx_und[0]); end
      exp_q.push_back({1'b0, 8'h12});
      exp_q.push_back({1'b1, 8'h34});
      spi_xfer(0, 64'h1234, 16, 1'b1, mb);
      checks++; if (mb[15:0] !== 16'hFFFF) begin errors++; $display("FAIL underrun_miso got %h want ffff", mb[15:0]); end
      checks++; if (tx_und[0] !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", tx_und[0]); end
      collect(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++; if (g !== e) begin errors++; $display("FAIL underrun_rx got %h want %h", g, e); end
      end
      pulse_clear();
      checks++; if (tx_und[0] !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", tx_und[0]); end
   endtask

   task automatic test_overflow();
      logic [63:0] mb;
      logic [W:0]  e, g;
      for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 8'(i)});
      spi_xfer(0, 64'h010203040506, 48, 1'b1, mb);
      checks++; if (rx_level[0] !== 3'd4) begin errors++; $display("FAIL overflow_level got %0d want 4", rx_level[0]); end
      checks++; if (rx_ovf[0] !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b want 1", rx_ovf[0]); end
      checks++; if ({m_tvalid[0], m_tdata[0]} !== {1'b1, 8'h01}) begin errors++; $display("FAIL overflow_head got %h want 101", {m_tvalid[0], m_tdata[0]}); end
      collect(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++; if (g !== e) begin errors++; $display("FAIL overflow_rx got %h want %h", g, e); end
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL overflow_extra got %0d words want 0", got_q.size()); end
      checks++; if ({rx_level[0], rx_ovf[0]} !== 4'b0001) begin errors++; $display("FAIL overflow_after got level %0d flag %b want 0 1", rx_level[0], rx_ovf[0]); end
      pulse_clear();
   endtask

   task automatic test_partial();
      logic [63:0] mb;
      logic [W:0]  e, g;
      exp_q.push_back({1'b1, 8'h96});
      spi_xfer(0, 64'h96A, 12, 1'b1, mb);
      checks++; if (rx_level[0] !== 3'd1) begin errors++; $display("FAIL partial_level got %0d want 1", rx_level[0]); end
      collect(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++; if (g !== e) begin errors++; $display("FAIL partial_rx got %h want %h", g, e); end
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL partial_extra got %0d words want 0", got_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] mb;
      logic [W:0]  e, g;
      axis_push(0, 8'h77);
      spi_xfer(0, 64'hC, 4, 1'b0, mb);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({rx_level[0], tx_level[0]} !== 8'd0) begin errors++; $display("FAIL midreset_levels got %0d/%0d want 0/0", rx_level[0], tx_level[0]); end
      checks++; if ({m_tvalid[0], miso_oe[0]} !== 2'b00) begin errors++; $display("FAIL midreset_tvalid_oe got %b want 00", {m_tvalid[0], miso_oe[0]}); end
      cs_n[0] = 1'b1;
      #200;
      exp_q.push_back({1'b1, 8'hC3});
      spi_xfer(0, 64'hC3, 8, 1'b1, mb);
      collect(0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++; if (g !== e) begin errors++; $display("FAIL midreset_rx got %h want %h", g, e); end
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midreset_extra got %0d words want 0", got_q.size()); end
   endtask

   initial begin
      rst     = 1'b1;
      clr     = 1'b0;
      mosi    = 1'b0;
      s_tdata = '0;
      for (int i = 0; i < 4; i++) begin
         spi_clk[i]  = (i / 2) != 0;
         cs_n[i]     = 1'b1;
         s_tvalid[i] = 1'b0;
         m_tready[i] = 1'b0;
      end
      test_reset();
      test_mode0_frame();
      test_modes();
      test_underrun();
      test_overflow();
      test_partial();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
